// File: rtl/mem_responder.sv
// Memory-side responder: accepts one data access, waits LATENCY cycles,
// strobes a single memory read or write, then holds the response until taken.
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [3:0]            i_req_wmask,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_is_store,
  output logic                  o_mem_re,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]            o_mem_wmask,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wmask;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_is_store;
  logic                  w_fire;

  // The access happens on the edge that leaves WAIT, so exactly once.
  assign w_fire = (r_state == S_WAIT) && (r_cnt == 4'd0);

  assign o_req_ready     = (r_state == S_IDLE) && !i_rst;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_resp_is_store = r_resp_is_store;
  assign o_mem_re        = w_fire && !r_wen;
  assign o_mem_we        = w_fire && r_wen && (r_wmask != 4'd0);
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_wmask     = {4'b0, r_wmask};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= 4'd0;
      r_wen           <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wmask         <= 4'd0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_is_store <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_wen   <= i_req_wen;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_wmask <= i_req_wmask;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state         <= S_RESP;
            r_resp_valid    <= 1'b1;
            r_resp_is_store <= r_wen;
            r_resp_rdata    <= r_wen ? '0 : i_mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the load/store stage's data accesses. It is the slave end of the data-memory interface. It accepts one request at a time over a valid/ready channel and waits a programmable number of cycles. It then performs exactly one `mem_read` or `mem_write` DPI-C call and returns the read word over a valid/ready response channel. The block sits between the load/store unit and the simulated memory, and replaces zero-latency combinational DPI access with realistic, stallable timing.

## Interface
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: data width; all DPI transfers are 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_wen` input 1: 1 = store, 0 = load.
- `req_addr` input ADDR_WIDTH: byte address, passed unmodified to DPI.
- `req_wdata` input DATA_WIDTH: store data.
- `req_wmask` input 4: byte enables for stores, passed as `{4'b0, req_wmask}`.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: requester accepts the response.
- `resp_rdata` output DATA_WIDTH: loaded word; 0 for stores.
- `resp_is_store` output 1: echo of the latched `req_wen`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` = ~rst.
  - On `req_valid & req_ready`, latch wen/addr/wdata/wmask, load the counter with LATENCY-1, and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, perform the access at that edge and go to RESP:
    - Load: `resp_rdata <= mem_read(addr)`.
    - Store with nonzero mask: call `mem_write(addr, wdata, {4'b0, wmask})` once; `resp_rdata <= 0`.
    - Store with mask 0: no DPI call; the response is still returned.
- RESP:
  - `resp_valid` = 1; `resp_rdata` and `resp_is_store` are held stable.
  - On `resp_ready`, go to IDLE.
  - `req_ready` is 0 in this state; a new request is never accepted in the response-handshake cycle.
- Exactly one DPI call per accepted request. No DPI call on reset, in IDLE, or while stalled in RESP.
- Request inputs are ignored outside IDLE; latched values are immune to later input changes.
- Counter width: 4 bits; it never wraps because it reloads only on acceptance.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, counter = 0.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_is_store` = 0.
  - `req_ready` = 0 while rst is high, then 1 in the first cycle after release.
- Acceptance at edge T yields `resp_valid` = 1 from cycle T+LATENCY. LATENCY = 1 means a response in the cycle after acceptance.
- The DPI access occurs at the edge that sets `resp_valid`.
- Minimum request-to-request spacing is LATENCY+2 cycles (accept, LATENCY cycles, handshake, IDLE).
- Backpressure: `resp_valid` stays asserted indefinitely until `resp_ready`; data is unchanged throughout.
- Reset in WAIT: the request is dropped and no memory access occurs.
- Reset in RESP: the response is dropped; a store already written stays written.

## Test plan
- Load, LATENCY=2, memory[0x80000010]=0xDEADBEEF: accept at cycle 0 -> `resp_valid` at cycle 2, rdata=0xDEADBEEF, `resp_is_store`=0, exactly one `mem_read`.
- Store addr 0x80000020, data 0x11223344, mask 4'b0011, then a load of the same address -> one `mem_write` with mask 8'h03; the load returns low half 0x3344 merged with prior upper bytes; store response rdata=0.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid` -> valid and rdata stable, `req_ready`=0, no extra DPI calls; release -> IDLE next cycle, `req_ready`=1.
- Store with mask 0 -> no `mem_write` call; response still arrives at LATENCY with `resp_is_store`=1.
- Assert rst asynchronously in WAIT of a store -> outputs clear without waiting for a clock edge; memory is unchanged; `req_ready`=1 one cycle after release.
- LATENCY=1, back-to-back `req_valid` held high with `resp_ready`=1 -> accepts every 3 cycles; changing `req_addr` while in WAIT does not affect the accessed address.
